// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode, execute,
// memory and writeback, flags unsupported instructions and counts retired ones.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    output logic [3:0]  alu_control,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        zero_ext,
    output logic [1:0]  pc_source,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtExec = 4'd6,
        StRtWb   = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StIExec  = 4'd10,
        StIWb    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    state_e     state_q, state_d;
    logic [5:0] op_q, funct_q;
    logic       dec_illegal;
    logic       retire;

    // Decode uses the live opcode/funct; later states use the copies latched in DECODE.
    always_comb begin
        state_d     = StFetch;
        dec_illegal = 1'b0;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                unique case (opcode)
                    OpRtype: begin
                        unique case (funct)
                            FnAdd, FnSub, FnAnd, FnOr, FnNor, FnSlt: state_d = StRtExec;
                            default:                                 dec_illegal = 1'b1;
                        endcase
                    end
                    OpLw, OpSw:            state_d = StMemAdr;
                    OpBeq, OpBne:          state_d = StBranch;
                    OpJ:                   state_d = StJump;
                    OpAddi, OpAndi, OpOri: state_d = StIExec;
                    default:               dec_illegal = 1'b1;
                endcase
            end
            StMemAdr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
            StMemRd:  state_d = StMemWb;
            StRtExec: state_d = StRtWb;
            StIExec:  state_d = StIWb;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        unique case (state_q)
            StMemWb, StMemWr, StRtWb, StBranch, StJump, StIWb: retire = 1'b1;
            default:                                           retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            op_q        <= '0;
            funct_q     <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
            if (dec_illegal) illegal <= 1'b1;
            if (retire) instr_count <= instr_count + 32'd1;
        end
    end

    always_comb begin
        alu_control = AluAdd;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        zero_ext    = 1'b0;
        pc_source   = 2'b00;
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_en     = 1'b1;
            end
            StDecode: alu_src_b = 2'b11;
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StRtExec: begin
                alu_src_a = 1'b1;
                unique case (funct_q)
                    FnSub:   alu_control = AluSub;
                    FnAnd:   alu_control = AluAnd;
                    FnOr:    alu_control = AluOr;
                    FnNor:   alu_control = AluNor;
                    FnSlt:   alu_control = AluSlt;
                    default: alu_control = AluAdd;
                endcase
            end
            StRtWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBranch: begin
                alu_src_a   = 1'b1;
                alu_control = AluSub;
                pc_source   = 2'b01;
                pc_en       = (op_q == OpBne) ? ~alu_zero : alu_zero;
            end
            StJump: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                zero_ext  = (op_q == OpAndi) || (op_q == OpOri);
                unique case (op_q)
                    OpAndi:  alu_control = AluAnd;
                    OpOri:   alu_control = AluOr;
                    default: alu_control = AluAdd;
                endcase
            end
            StIWb: begin
                reg_write = 1'b1;
                zero_ext  = (op_q == OpAndi) || (op_q == OpOri);
            end
            default: ;
        endcase
        // Reset abandons the current instruction: no side-effecting strobe may fire.
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of instructions feeding a per-cycle
// scoreboard of expected control words, plus a hand-written mid-instruction reset case.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        alu_zero;
    logic [3:0]  alu_control;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        zero_ext;
    logic [1:0]  pc_source;
    logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instr_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .alu_zero    (alu_zero),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .zero_ext    (zero_ext),
        .pc_source   (pc_source),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .state       (state),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    logic [21:0] act_ctrl;
    assign act_ctrl = {state, alu_control, alu_src_a, alu_src_b, zero_ext, pc_source,
                       pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg};

    typedef struct {
        logic [5:0]      op;
        logic [5:0]      fn;
        logic            z;
        int              n;
        logic [4:0][3:0] st;
        logic            ill;
        logic [31:0]     cnt;
    } vec_t;

    typedef struct {
        logic [21:0] ctrl;
        int          vec;
        int          step;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int n, input int s0, input int s1, input int s2,
                                input int s3, input int s4, input logic ill,
                                input int cnt);
        vec_t v;
        v.op  = op;
        v.fn  = fn;
        v.z   = z;
        v.n   = n;
        v.st  = {s4[3:0], s3[3:0], s2[3:0], s1[3:0], s0[3:0]};
        v.ill = ill;
        v.cnt = cnt;
        return v;
    endfunction

    // Expected control word for one state of a given instruction, straight from the state table.
    function automatic logic [21:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z);
        logic [3:0] alu;
        logic       sa, ze, pe, io, mr, mw, iw, rw, rd, mtr;
        logic [1:0] sb_, ps;
        alu = 4'b0010; sa = 0; sb_ = 2'b00; ze = 0; ps = 2'b00;
        pe = 0; io = 0; mr = 0; mw = 0; iw = 0; rw = 0; rd = 0; mtr = 0;
        case (st)
            4'd0: begin mr = 1; iw = 1; sb_ = 2'b01; pe = 1; end
            4'd1: sb_ = 2'b11;
            4'd2: begin sa = 1; sb_ = 2'b10; end
            4'd3: begin mr = 1; io = 1; end
            4'd4: begin rw = 1; mtr = 1; end
            4'd5: begin mw = 1; io = 1; end
            4'd6: begin
                sa = 1;
                case (fn)
                    6'h22: alu = 4'b0110;
                    6'h24: alu = 4'b0000;
                    6'h25: alu = 4'b0001;
                    6'h27: alu = 4'b1100;
                    6'h2A: alu = 4'b0111;
                    default: alu = 4'b0010;
                endcase
            end
            4'd7: begin rw = 1; rd = 1; end
            4'd8: begin sa = 1; alu = 4'b0110; ps = 2'b01; pe = (op == 6'h04) ? z : ~z; end
            4'd9: begin ps = 2'b10; pe = 1; end
            4'd10: begin
                sa = 1; sb_ = 2'b10;
                if (op == 6'h0C) begin alu = 4'b0000; ze = 1; end
                if (op == 6'h0D) begin alu = 4'b0001; ze = 1; end
            end
            4'd11: begin rw = 1; ze = (op == 6'h0C) || (op == 6'h0D); end
            default: ;
        endcase
        return {st, alu, sa, sb_, ze, ps, pe, io, mr, mw, iw, rw, rd, mtr};
    endfunction

    initial begin
        exp_t e;
        vecs[0]  = mk(6'h00, 6'h20, 0, 4, 0, 1, 6, 7, 0, 0, 1);   // add
        vecs[1]  = mk(6'h23, 6'h00, 0, 5, 0, 1, 2, 3, 4, 0, 2);   // lw
        vecs[2]  = mk(6'h2B, 6'h00, 0, 4, 0, 1, 2, 5, 0, 0, 3);   // sw
        vecs[3]  = mk(6'h04, 6'h00, 1, 3, 0, 1, 8, 0, 0, 0, 4);   // beq taken
        vecs[4]  = mk(6'h05, 6'h00, 1, 3, 0, 1, 8, 0, 0, 0, 5);   // bne not taken
        vecs[5]  = mk(6'h3F, 6'h00, 0, 2, 0, 1, 0, 0, 0, 1, 5);   // unsupported opcode
        vecs[6]  = mk(6'h02, 6'h00, 0, 3, 0, 1, 9, 0, 0, 1, 6);   // j
        vecs[7]  = mk(6'h00, 6'h2A, 0, 4, 0, 1, 6, 7, 0, 1, 7);   // slt
        vecs[8]  = mk(6'h00, 6'h27, 0, 4, 0, 1, 6, 7, 0, 1, 8);   // nor
        vecs[9]  = mk(6'h0D, 6'h00, 0, 4, 0, 1, 10, 11, 0, 1, 9); // ori
        vecs[10] = mk(6'h00, 6'h22, 0, 4, 0, 1, 6, 7, 0, 1, 10);  // sub
        vecs[11] = mk(6'h00, 6'h24, 0, 4, 0, 1, 6, 7, 0, 1, 11);  // and
        vecs[12] = mk(6'h00, 6'h25, 0, 4, 0, 1, 6, 7, 0, 1, 12);  // or
        vecs[13] = mk(6'h08, 6'h00, 0, 4, 0, 1, 10, 11, 0, 1, 13); // addi
        vecs[14] = mk(6'h0C, 6'h00, 1, 4, 0, 1, 10, 11, 0, 1, 14); // andi
        vecs[15] = mk(6'h04, 6'h00, 0, 3, 0, 1, 8, 0, 0, 1, 15);  // beq not taken
        vecs[16] = mk(6'h05, 6'h00, 0, 3, 0, 1, 8, 0, 0, 1, 16);  // bne taken
        vecs[17] = mk(6'h00, 6'h01, 0, 2, 0, 1, 0, 0, 0, 1, 16);  // unsupported funct

        reset = 1; opcode = 0; funct = 0; alu_zero = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(state), 0);
        check("reset_strobes", 32'({pc_en, ir_write, mem_read, mem_write, reg_write}), 0);
        reset = 0;
        #1;
        check("reset_illegal", 32'(illegal), 0);
        check("reset_count", instr_count, 0);

        for (int i = 0; i < 18; i++) begin
            opcode = vecs[i].op; funct = vecs[i].fn; alu_zero = vecs[i].z;
            for (int k = 0; k < vecs[i].n; k++) begin
                e.ctrl = exp_ctrl(vecs[i].st[k], vecs[i].op, vecs[i].fn, vecs[i].z);
                e.vec  = i;
                e.step = k;
                sb.push_back(e);
            end
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (act_ctrl !== e.ctrl) begin
                    failures++;
                    $display("FAIL ctrl vec%0d step%0d: got 0x%06h expected 0x%06h",
                             e.vec, e.step, act_ctrl, e.ctrl);
                end
                @(negedge clk);
                #1;
            end
            check($sformatf("next_fetch vec%0d", i), 32'(state), 0);
            check($sformatf("illegal vec%0d", i), 32'(illegal), 32'(vecs[i].ill));
            check($sformatf("count vec%0d", i), instr_count, vecs[i].cnt);
        end

        // sw interrupted by a one-cycle reset while in MEMWR.
        opcode = 6'h2B; funct = 0; alu_zero = 0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_state_memwr", 32'(state), 5);
        check("mid_memwrite_before", 32'(mem_write), 1);
        reset = 1;
        #1;
        check("mid_strobes_in_reset",
              32'({pc_en, ir_write, mem_read, mem_write, reg_write}), 0);
        @(negedge clk);
        reset = 0;
        #1;
        check("mid_state_after", 32'(state), 0);
        check("mid_illegal_after", 32'(illegal), 0);
        check("mid_count_after", instr_count, 0);
        check("mid_fetch_strobes", 32'({pc_en, ir_write, mem_read}), 32'b111);
        @(negedge clk);
        #1;
        check("mid_decode", 32'(state), 1);
        check("mid_count_decode", instr_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
